// File: rtl/lcg_pkg.sv
// Shared types and default constants for the LCG next-state stage.
// The state enum and default generator parameters live here for the sequencer and its siblings.
package lcg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ADD  = 2'd2,
        ST_OUT  = 2'd3
    } lcg_state_e;

    localparam int LCG_WIDTH    = 4;
    localparam int LCG_A        = 5;
    localparam int LCG_C        = 3;
    localparam int LCG_SEED     = 1;
    localparam int LCG_MULT_LAT = 2;

endpackage

// File: rtl/lcg_sequencer.sv
// LCG next-state stage: sequences an external serial multiplier, adds C to its product and
// presents x_{n+1} = (A*x_n + C) mod 2^WIDTH on a valid/ready output.
module lcg_sequencer
    import lcg_pkg::*;
#(
    parameter int WIDTH    = LCG_WIDTH,
    parameter int A        = LCG_A,
    parameter int C        = LCG_C,
    parameter int SEED     = LCG_SEED,
    parameter int MULT_LAT = LCG_MULT_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gen_enable,
    input  logic                 seed_load,
    input  logic [WIDTH-1:0]     seed_data,
    output logic [WIDTH-1:0]     mult_multiplicand,
    output logic [WIDTH-1:0]     mult_multiplier,
    output logic                 mult_enable,
    input  logic [2*WIDTH-1:0]   mult_result,
    input  logic                 mult_done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 err_mult
);

    localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MULT_LAT - 1);
    localparam logic [WIDTH-1:0]   A_W      = WIDTH'(A);
    localparam logic [WIDTH-1:0]   SEED_W   = WIDTH'(SEED);
    localparam logic [2*WIDTH-1:0] C_EXT    = (2*WIDTH)'(C);

    lcg_state_e       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mult_en_q, mult_en_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] next_x;

    // Sum is formed at full product width; truncation is the mod 2^WIDTH.
    assign next_x = WIDTH'(mult_result + C_EXT);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        cnt_d       = cnt_q;
        mult_en_d   = mult_en_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_d       = err_q;

        if (seed_load) begin
            x_d         = seed_data;
            cnt_d       = '0;
            mult_en_d   = 1'b0;
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gen_enable) begin
                        state_d   = ST_MUL;
                        mult_en_d = 1'b1;
                        cnt_d     = '0;
                    end
                end
                ST_MUL: begin
                    // Completion is count-based: mult_done stays high once set.
                    if (cnt_q == CNT_LAST) begin
                        mult_en_d = 1'b0;
                        state_d   = ST_ADD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_ADD: begin
                    if (!mult_done) begin
                        err_d = 1'b1;
                    end
                    x_d         = next_x;
                    out_data_d  = next_x;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
                ST_OUT: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        if (gen_enable) begin
                            state_d   = ST_MUL;
                            mult_en_d = 1'b1;
                            cnt_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    mult_en_d   = 1'b0;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            x_q         <= SEED_W;
            cnt_q       <= '0;
            mult_en_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            cnt_q       <= cnt_d;
            mult_en_q   <= mult_en_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    assign mult_multiplicand = x_q;
    assign mult_multiplier   = A_W;
    assign mult_enable       = mult_en_q;
    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign err_mult          = err_q;

endmodule

// File: tb/tb_lcg_sequencer.sv
// Directed bench for lcg_sequencer with a behavioural stand-in for the sibling multiplier.
module tb_lcg_sequencer;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           gen_enable;
    logic           seed_load;
    logic [W-1:0]   seed_data;
    logic [W-1:0]   mult_multiplicand;
    logic [W-1:0]   mult_multiplier;
    logic           mult_enable;
    logic [2*W-1:0] mult_result;
    logic           mult_done;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           err_mult;

    logic [2*W-1:0] prod_q;
    logic           done_q;
    logic           force_done_low;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lcg_sequencer #(.WIDTH(W), .A(5), .C(3), .SEED(1), .MULT_LAT(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .gen_enable        (gen_enable),
        .seed_load         (seed_load),
        .seed_data         (seed_data),
        .mult_multiplicand (mult_multiplicand),
        .mult_multiplier   (mult_multiplier),
        .mult_enable       (mult_enable),
        .mult_result       (mult_result),
        .mult_done         (mult_done),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .err_mult          (err_mult)
    );

    // Multiplier stand-in: product registered while enabled, done sticky, reset by ~rst.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prod_q <= '0;
            done_q <= 1'b0;
        end else if (mult_enable) begin
            prod_q <= {{W{1'b0}}, mult_multiplicand} * {{W{1'b0}}, mult_multiplier};
            done_q <= 1'b1;
        end
    end
    assign mult_result = prod_q;
    assign mult_done   = done_q & ~force_done_low;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        gen_enable = 1'b0;
        seed_load = 1'b0;
        seed_data = '0;
        out_ready = 1'b0;
        force_done_low = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output int edges, output bit ok);
        edges = 0;
        while (edges < budget && !out_valid) begin
            tick();
            edges++;
        end
        ok = out_valid;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({out_valid, out_data, mult_enable, err_mult} !== {1'b0, 4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b d=%0d en=%0b err=%0b, want 0 0 0 0",
                     out_valid, out_data, mult_enable, err_mult);
        end
        n_cmp++;
        if (mult_multiplicand !== 4'd1 || mult_multiplier !== 4'd5) begin
            n_fail++;
            $display("FAIL reset_operands: got x=%0d a=%0d, want 1 5", mult_multiplicand, mult_multiplier);
        end
    endtask

    task automatic test_sequence();
        logic [W-1:0] exp_v [4] = '{4'd8, 4'd11, 4'd10, 4'd5};
        int edges;
        bit ok;
        do_reset();
        gen_enable = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            wait_valid(20, edges, ok);
            n_cmp++;
            if (!ok || out_data !== exp_v[i]) begin
                n_fail++;
                $display("FAIL seq_value[%0d]: got %0d (valid=%0b), want %0d", i, out_data, ok, exp_v[i]);
            end
            n_cmp++;
            if (edges !== ((i == 0) ? 4 : 3)) begin
                n_fail++;
                $display("FAIL seq_latency[%0d]: got %0d edges, want %0d", i, edges, (i == 0) ? 4 : 3);
            end
        end
    endtask

    task automatic test_full_period();
        logic [W-1:0] first;
        logic [15:0]  seen;
        int dups;
        int edges;
        bit ok;
        seen = '0;
        dups = 0;
        first = '0;
        do_reset();
        gen_enable = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (i > 0) tick();
            wait_valid(20, edges, ok);
            if (!ok) dups++;
            if (i == 0) first = out_data;
            if (i < 16) begin
                if (seen[out_data]) dups++;
                seen[out_data] = 1'b1;
            end else begin
                n_cmp++;
                if (out_data !== first || out_data !== 4'd8) begin
                    n_fail++;
                    $display("FAIL period_wrap: got %0d, want 8 (first=%0d)", out_data, first);
                end
            end
        end
        n_cmp++;
        if (seen !== 16'hFFFF || dups != 0) begin
            n_fail++;
            $display("FAIL period_cover: got seen=%h dups=%0d, want ffff 0", seen, dups);
        end
    endtask

    task automatic test_backpressure();
        int edges;
        bit ok;
        bit held;
        do_reset();
        gen_enable = 1'b1;
        out_ready = 1'b0;
        wait_valid(20, edges, ok);
        n_cmp++;
        if (!ok || out_data !== 4'd8) begin
            n_fail++;
            $display("FAIL bp_first: got %0d valid=%0b, want 8", out_data, ok);
        end
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_data !== 4'd8 || mult_enable !== 1'b0) held = 1'b0;
        end
        n_cmp++;
        if (!held) begin
            n_fail++;
            $display("FAIL bp_hold: got v=%0b d=%0d en=%0b, want 1 8 0", out_valid, out_data, mult_enable);
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || mult_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got v=%0b en=%0b, want 0 1", out_valid, mult_enable);
        end
        wait_valid(20, edges, ok);
        n_cmp++;
        if (!ok || out_data !== 4'd11) begin
            n_fail++;
            $display("FAIL bp_next: got %0d valid=%0b, want 11", out_data, ok);
        end
    endtask

    task automatic test_seed_load();
        int edges;
        bit ok;
        do_reset();
        gen_enable = 1'b1;
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (mult_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL seed_in_mul: got en=%0b, want 1", mult_enable);
        end
        seed_load = 1'b1;
        seed_data = 4'd7;
        tick();
        seed_load = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || mult_enable !== 1'b0 || mult_multiplicand !== 4'd7) begin
            n_fail++;
            $display("FAIL seed_abort: got v=%0b en=%0b x=%0d, want 0 0 7",
                     out_valid, mult_enable, mult_multiplicand);
        end
        wait_valid(20, edges, ok);
        n_cmp++;
        if (!ok || out_data !== 4'd6 || edges !== 4) begin
            n_fail++;
            $display("FAIL seed_next: got %0d after %0d edges valid=%0b, want 6 after 4", out_data, edges, ok);
        end
    endtask

    task automatic test_reset_mid_add();
        int edges;
        bit ok;
        do_reset();
        gen_enable = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({out_valid, out_data, mult_enable, err_mult, mult_multiplicand} !== {1'b0, 4'd0, 1'b0, 1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL rst_mid_add: got v=%0b d=%0d en=%0b err=%0b x=%0d, want 0 0 0 0 1",
                     out_valid, out_data, mult_enable, err_mult, mult_multiplicand);
        end
        rst = 1'b1;
        wait_valid(20, edges, ok);
        n_cmp++;
        if (!ok || out_data !== 4'd8) begin
            n_fail++;
            $display("FAIL rst_restart: got %0d valid=%0b, want 8", out_data, ok);
        end
    endtask

    task automatic test_gen_drop();
        int edges;
        bit ok;
        bit idle;
        do_reset();
        gen_enable = 1'b1;
        out_ready = 1'b1;
        tick();
        gen_enable = 1'b0;
        wait_valid(20, edges, ok);
        n_cmp++;
        if (!ok || out_data !== 4'd8) begin
            n_fail++;
            $display("FAIL gen_drop_value: got %0d valid=%0b, want 8", out_data, ok);
        end
        idle = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid !== 1'b0 || mult_enable !== 1'b0) idle = 1'b0;
        end
        n_cmp++;
        if (!idle) begin
            n_fail++;
            $display("FAIL gen_drop_idle: got v=%0b en=%0b, want 0 0", out_valid, mult_enable);
        end
    endtask

    task automatic test_mult_error();
        int edges;
        bit ok;
        do_reset();
        force_done_low = 1'b1;
        gen_enable = 1'b1;
        out_ready = 1'b1;
        wait_valid(20, edges, ok);
        n_cmp++;
        if (!ok || out_data !== 4'd8 || err_mult !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: got d=%0d err=%0b valid=%0b, want 8 1", out_data, err_mult, ok);
        end
        force_done_low = 1'b0;
        tick();
        wait_valid(20, edges, ok);
        n_cmp++;
        if (!ok || out_data !== 4'd11 || err_mult !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got d=%0d err=%0b valid=%0b, want 11 1", out_data, err_mult, ok);
        end
        do_reset();
        n_cmp++;
        if (err_mult !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got %0b, want 0", err_mult);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_full_period();
        test_backpressure();
        test_seed_load();
        test_reset_mid_add();
        test_gen_drop();
        test_mult_error();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
